// File: rtl/n_bit_serial_subtractor_if.sv
// Operand/result handshake bundle for n_bit_serial_subtractor.
// master = operand producer / result consumer, slave = the subtractor.
interface n_bit_serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] minuend;
    logic [WIDTH-1:0] subtrahend;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             busy;

    modport master (
        output in_valid, minuend, subtrahend, out_ready,
        input  in_ready, out_valid, diff, borrow_out, busy
    );

    modport slave (
        input  in_valid, minuend, subtrahend, out_ready,
        output in_ready, out_valid, diff, borrow_out, busy
    );
endinterface

// File: rtl/n_bit_serial_subtractor.sv
// Multi-cycle unsigned subtractor: CHUNK bits per cycle, LSB chunk first, registered borrow.
// Optional macro SUB_SATURATE_EN clamps underflowing results to zero (borrow_out still 1).
module n_bit_serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    n_bit_serial_subtractor_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if ((WIDTH < 1) || (CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
        $error("n_bit_serial_subtractor: WIDTH must be a positive multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_borrow;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_out;
    logic             r_out_valid;
    logic             r_in_ready;
    logic             r_busy;

    logic [CHUNK:0]   w_sub;
    logic [CHUNK-1:0] w_d;
    logic             w_bnext;
    logic [WIDTH-1:0] w_res_next;
    logic [WIDTH-1:0] w_final;
    logic             w_last;

    // One chunk of the ripple subtract; the extra MSB of w_sub is the outgoing borrow.
    assign w_sub      = {1'b0, r_a[CHUNK-1:0]} - {1'b0, r_b[CHUNK-1:0]} - (CHUNK+1)'(r_borrow);
    assign w_d        = w_sub[CHUNK-1:0];
    assign w_bnext    = w_sub[CHUNK];
    assign w_res_next = WIDTH'({w_d, r_res} >> CHUNK);
    assign w_last     = (r_cnt == CW'(NCHUNK - 1));

`ifdef SUB_SATURATE_EN
    assign w_final = w_bnext ? {WIDTH{1'b0}} : w_res_next;
`else
    assign w_final = w_res_next;
`endif

    // Control FSM and datapath registers; all outputs come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= CW'(0);
            r_borrow     <= 1'b0;
            r_a          <= {WIDTH{1'b0}};
            r_b          <= {WIDTH{1'b0}};
            r_res        <= {WIDTH{1'b0}};
            r_diff       <= {WIDTH{1'b0}};
            r_borrow_out <= 1'b0;
            r_out_valid  <= 1'b0;
            r_in_ready   <= 1'b1;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_a        <= bus.minuend;
                        r_b        <= bus.subtrahend;
                        r_borrow   <= 1'b0;
                        r_cnt      <= CW'(0);
                        r_res      <= {WIDTH{1'b0}};
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_a      <= r_a >> CHUNK;
                    r_b      <= r_b >> CHUNK;
                    r_res    <= w_res_next;
                    r_borrow <= w_bnext;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_diff       <= w_final;
                        r_borrow_out <= w_bnext;
                        r_out_valid  <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Result is held until the consumer takes it; no accept in this state.
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.diff       = r_diff;
    assign bus.borrow_out = r_borrow_out;
    assign bus.busy       = r_busy;
endmodule
